uart_cmd_decoder: RTL and testbench

Receive-side command parser for the sensor node: consumes bytes from the UART receiver (`doutrx`/`donerx`) and produces the control inputs of the measurement/display top level (`mode`, `trig_newd12`, `I_Temp_war`, `I_Hum_war`). It decodes framed, checksummed 4-byte commands from the host. It validates range and checksum, abandons stalled frames on timeout, and signals each applied update to the OLED path with a toggle.

---
 rtl/uart_cmd_decoder_if.sv | 28 ++
 rtl/uart_cmd_decoder.sv | 149 ++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_decoder_if
//  Brief    : Byte stream in / control outputs out of the UART command decoder
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_decoder_if;
    logic       donerx;
    logic [7:0] doutrx;
    logic [1:0] mode;
    logic [6:0] I_Temp_war;
    logic [6:0] I_Hum_war;
    logic       trig_newd12;
    logic       cmd_ok;
    logic       cmd_err;
    logic [7:0] err_cnt;

    modport master (
        output donerx, doutrx,
        input  mode, I_Temp_war, I_Hum_war, trig_newd12, cmd_ok, cmd_err, err_cnt
    );

    modport slave (
        input  donerx, doutrx,
        output mode, I_Temp_war, I_Hum_war, trig_newd12, cmd_ok, cmd_err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_decoder
//  Brief    : Parses 0x55/CMD/DATA/SUM frames into mode and alarm thresholds
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYC  = 12_500_000,
    parameter logic [6:0]  TEMP_WAR_RST = 7'd40,
    parameter logic [6:0]  HUM_WAR_RST  = 7'd80
) (
    input  logic              clk,
    input  logic              rst,
    uart_cmd_decoder_if.slave bus
);

    localparam int unsigned c_CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] c_HEADER = 8'h55;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_GET_CMD  = 3'd1;
    localparam logic [2:0] c_GET_DATA = 3'd2;
    localparam logic [2:0] c_GET_SUM  = 3'd3;
    localparam logic [2:0] c_EXEC     = 3'd4;

    logic [2:0]         r_state;
    logic [7:0]         r_cmd;
    logic [7:0]         r_data;
    logic               r_sum_ok;
    logic [c_CNT_W-1:0] r_tmo_cnt;
    logic               r_pend_ok;
    logic               r_pend_err;
    logic [1:0]         r_mode;
    logic [6:0]         r_temp_war;
    logic [6:0]         r_hum_war;
    logic               r_trig;
    logic               r_cmd_ok;
    logic               r_cmd_err;
    logic [7:0]         r_err_cnt;
    logic               w_cmd_valid;

    always_comb begin
        w_cmd_valid = 1'b0;
        case (r_cmd)
            8'h01:        w_cmd_valid = (r_data[7:2] == 6'd0);
            8'h02, 8'h03: w_cmd_valid = (r_data <= 8'd99);
            8'h04:        w_cmd_valid = 1'b1;
            default:      w_cmd_valid = 1'b0;
        endcase
    end

    // EXEC decides into r_pend_*; the following edge applies it, so the
    // register update, toggle, pulse and error count all land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cmd      <= 8'h00;
            r_data     <= 8'h00;
            r_sum_ok   <= 1'b0;
            r_tmo_cnt  <= '0;
            r_pend_ok  <= 1'b0;
            r_pend_err <= 1'b0;
            r_mode     <= 2'd0;
            r_temp_war <= TEMP_WAR_RST;
            r_hum_war  <= HUM_WAR_RST;
            r_trig     <= 1'b0;
            r_cmd_ok   <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_err_cnt  <= 8'h00;
        end else begin
            r_pend_ok  <= 1'b0;
            r_pend_err <= 1'b0;
            r_cmd_ok   <= r_pend_ok;
            r_cmd_err  <= r_pend_err;

            if (r_pend_ok) begin
                case (r_cmd)
                    8'h01:   r_mode     <= r_data[1:0];
                    8'h02:   r_temp_war <= r_data[6:0];
                    8'h03:   r_hum_war  <= r_data[6:0];
                    default: ;
                endcase
                r_trig <= ~r_trig;
            end
            if (r_pend_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end

            case (r_state)
                c_IDLE: begin
                    r_tmo_cnt <= '0;
                    if (bus.donerx && (bus.doutrx == c_HEADER)) begin
                        r_state <= c_GET_CMD;
                    end
                end
                c_GET_CMD, c_GET_DATA, c_GET_SUM: begin
                    // An arriving byte takes priority over the terminal count.
                    if (bus.donerx) begin
                        r_tmo_cnt <= '0;
                        case (r_state)
                            c_GET_CMD: begin
                                r_cmd   <= bus.doutrx;
                                r_state <= c_GET_DATA;
                            end
                            c_GET_DATA: begin
                                r_data  <= bus.doutrx;
                                r_state <= c_GET_SUM;
                            end
                            default: begin
                                r_sum_ok <= (bus.doutrx == (r_cmd ^ r_data));
                                r_state  <= c_EXEC;
                            end
                        endcase
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_tmo_cnt  <= '0;
                        r_pend_err <= 1'b1;
                        r_state    <= c_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                c_EXEC: begin
                    r_tmo_cnt <= '0;
                    r_state   <= c_IDLE;
                    if (r_sum_ok && w_cmd_valid) begin
                        r_pend_ok <= 1'b1;
                    end else begin
                        r_pend_err <= 1'b1;
                    end
                end
                default: begin
                    r_tmo_cnt <= '0;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.mode        = r_mode;
    assign bus.I_Temp_war  = r_temp_war;
    assign bus.I_Hum_war   = r_hum_war;
    assign bus.trig_newd12 = r_trig;
    assign bus.cmd_ok      = r_cmd_ok;
    assign bus.cmd_err     = r_cmd_err;
    assign bus.err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_decoder
//  Brief    : Directed frames with hand-computed expectations for the decoder
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(
        .TIMEOUT_CYC  (50),
        .TEMP_WAR_RST (7'd40),
        .HUM_WAR_RST  (7'd80)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   n_ok   = 0;
    int   n_err  = 0;
    int   n_both = 0;
    int   n_wide = 0;
    logic prev_ok  = 1'b0;
    logic prev_err = 1'b0;

    // Pulse bookkeeping: totals, overlap, and any pulse wider than one cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cmd_ok)                 n_ok   <= n_ok + 1;
            if (bus.cmd_err)                n_err  <= n_err + 1;
            if (bus.cmd_ok && bus.cmd_err)  n_both <= n_both + 1;
            if ((bus.cmd_ok && prev_ok) || (bus.cmd_err && prev_err)) n_wide <= n_wide + 1;
        end
        prev_ok  <= bus.cmd_ok;
        prev_err <= bus.cmd_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.donerx = 1'b1;
        bus.doutrx = b;
        @(negedge clk);
        bus.donerx = 1'b0;
    endtask

    // Returns two edges after the SUM strobe, where the result is visible.
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] sum);
        send_byte(8'h55);
        send_byte(cmd);
        send_byte(data);
        send_byte(sum);
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc;
        bit  seen;
        logic [7:0] burst [5];

        bus.donerx = 1'b0;
        bus.doutrx = 8'h00;
        rst = 1'b1;
        idle(3);
        check("rst_mode",    32'(bus.mode), 0);
        check("rst_temp",    32'(bus.I_Temp_war), 40);
        check("rst_hum",     32'(bus.I_Hum_war), 80);
        check("rst_trig",    32'(bus.trig_newd12), 0);
        check("rst_ok",      32'(bus.cmd_ok), 0);
        check("rst_err",     32'(bus.cmd_err), 0);
        check("rst_err_cnt", 32'(bus.err_cnt), 0);
        rst = 1'b0;
        idle(2);

        // Set temperature 35, with exact two-edge latency after SUM.
        send_byte(8'h55);
        send_byte(8'h02);
        send_byte(8'h23);
        send_byte(8'h21);
        idle(1);
        check("temp_n1_ok",   32'(bus.cmd_ok), 0);
        check("temp_n1_val",  32'(bus.I_Temp_war), 40);
        idle(1);
        check("temp_n2_ok",   32'(bus.cmd_ok), 1);
        check("temp_n2_val",  32'(bus.I_Temp_war), 35);
        check("temp_n2_trig", 32'(bus.trig_newd12), 1);
        idle(1);
        check("temp_ok_fall", 32'(bus.cmd_ok), 0);

        send_frame(8'h01, 8'h02, 8'h03);
        check("mode_val",  32'(bus.mode), 2);
        check("mode_trig", 32'(bus.trig_newd12), 0);
        send_frame(8'h03, 8'h46, 8'h45);
        check("hum_val",   32'(bus.I_Hum_war), 70);
        check("hum_trig",  32'(bus.trig_newd12), 1);
        check("hum_errc",  32'(bus.err_cnt), 0);

        send_frame(8'h02, 8'h64, 8'h66);
        check("range_err",  32'(bus.cmd_err), 1);
        check("range_ok",   32'(bus.cmd_ok), 0);
        check("range_errc", 32'(bus.err_cnt), 1);
        check("range_temp", 32'(bus.I_Temp_war), 35);
        send_frame(8'h04, 8'h00, 8'h05);
        check("sum_errc",   32'(bus.err_cnt), 2);
        check("sum_trig",   32'(bus.trig_newd12), 1);
        send_frame(8'h07, 8'h00, 8'h07);
        check("cmd_errc",   32'(bus.err_cnt), 3);

        send_byte(8'h12);
        send_byte(8'hAA);
        idle(4);
        check("noise_nok",  32'(n_ok), 3);
        check("noise_nerr", 32'(n_err), 3);

        // Stall after CMD: error expected one edge after the terminal count.
        send_byte(8'h55);
        send_byte(8'h02);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.cmd_err) begin
                seen = 1'b1;
                cyc  = i;
            end
        end
        check("tmo_seen",   32'(seen), 1);
        check("tmo_window", 32'((cyc >= 49) && (cyc <= 52)), 1);
        idle(2);
        check("tmo_errc",   32'(bus.err_cnt), 4);
        send_frame(8'h04, 8'h00, 8'h04);
        check("post_tmo_ok",   32'(bus.cmd_ok), 1);
        check("post_tmo_trig", 32'(bus.trig_newd12), 0);

        // Next byte lands exactly on the terminal-count cycle and must win.
        send_byte(8'h55);
        idle(48);
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h04);
        idle(2);
        check("edge_ok",   32'(bus.cmd_ok), 1);
        check("edge_errc", 32'(bus.err_cnt), 4);
        check("edge_trig", 32'(bus.trig_newd12), 1);

        // Header back-to-back with SUM falls into EXEC and is dropped.
        burst = '{8'h55, 8'h04, 8'h00, 8'h04, 8'h55};
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.donerx = 1'b1;
            bus.doutrx = burst[i];
            @(negedge clk);
        end
        bus.donerx = 1'b0;
        idle(1);
        check("burst_ok", 32'(bus.cmd_ok), 1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        idle(4);
        check("burst_mode", 32'(bus.mode), 2);
        check("burst_nok",  32'(n_ok), 6);
        check("burst_trig", 32'(bus.trig_newd12), 0);

        // Reset mid-frame.
        send_byte(8'h55);
        send_byte(8'h01);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_mode", 32'(bus.mode), 0);
        check("mid_rst_temp", 32'(bus.I_Temp_war), 40);
        check("mid_rst_hum",  32'(bus.I_Hum_war), 80);
        check("mid_rst_errc", 32'(bus.err_cnt), 0);
        check("mid_rst_err",  32'(bus.cmd_err), 0);
        rst = 1'b0;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        idle(4);
        check("after_rst_mode", 32'(bus.mode), 0);
        check("after_rst_trig", 32'(bus.trig_newd12), 0);
        check("after_rst_nok",  32'(n_ok), 6);
        check("after_rst_nerr", 32'(n_err), 4);

        // Saturation of the error counter.
        for (int i = 0; i < 260; i++) begin
            send_frame(8'h07, 8'h00, 8'h07);
            if (i == 253) check("sat_254", 32'(bus.err_cnt), 254);
            if (i == 254) check("sat_255", 32'(bus.err_cnt), 255);
        end
        check("sat_final",    32'(bus.err_cnt), 255);
        check("sat_last_err", 32'(bus.cmd_err), 1);
        idle(3);
        check("sat_nerr",  32'(n_err), 264);
        check("no_overlap", 32'(n_both), 0);
        check("pulse_width", 32'(n_wide), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
